// File: rtl/alarm_controller.sv
// Alarm controller: stores an hour:minute alarm, compares it with live time
// at each minute boundary and runs the arm / ring / snooze state machine.
module alarm_controller #(
    parameter int unsigned P_SEC_BIT    = 6,
    parameter int unsigned P_MIN_BIT    = 6,
    parameter int unsigned P_HOUR_BIT   = 5,
    parameter int unsigned P_RING_SEC   = 60,
    parameter int unsigned P_SNOOZE_SEC = 300
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [P_SEC_BIT-1:0]  i_sec,
    input  logic [P_MIN_BIT-1:0]  i_minute,
    input  logic [P_HOUR_BIT-1:0] i_hour,
    input  logic                  i_arm,
    input  logic                  i_set_en,
    input  logic [P_HOUR_BIT-1:0] i_set_hour,
    input  logic [P_MIN_BIT-1:0]  i_set_min,
    input  logic                  i_snooze,
    input  logic                  i_stop,
    output logic                  o_ringing,
    output logic                  o_snoozing,
    output logic                  o_armed,
    output logic [P_HOUR_BIT-1:0] o_alarm_hour,
    output logic [P_MIN_BIT-1:0]  o_alarm_min,
    output logic                  o_set_err
);

    typedef enum logic [1:0] {StIdle, StArmed, StRinging, StSnooze} state_t;

    state_t                r_state;
    state_t                w_state_d;
    logic [7:0]            r_ring_cnt;
    logic [7:0]            w_ring_cnt_d;
    logic [11:0]           r_snz_cnt;
    logic [11:0]           w_snz_cnt_d;
    logic [P_SEC_BIT-1:0]  r_sec_d;
    logic [P_HOUR_BIT-1:0] r_alarm_hour;
    logic [P_MIN_BIT-1:0]  r_alarm_min;
    logic                  r_set_err;

    logic w_sec_tick;
    logic w_min_edge;
    logic w_match;
    logic w_set_ok;
    logic w_set_bad;

    // Any change of the seconds value is a tick, so a jump back to 0 also counts.
    assign w_sec_tick = (i_sec != r_sec_d);
    assign w_min_edge = w_sec_tick && (i_sec == '0);
    // Compares against the alarm held before any same-cycle set.
    assign w_match    = w_min_edge && (i_minute == r_alarm_min) && (i_hour == r_alarm_hour);
    assign w_set_ok   = i_set_en && (i_set_hour <= P_HOUR_BIT'(23))
                                 && (i_set_min <= P_MIN_BIT'(59));
    assign w_set_bad  = i_set_en && !w_set_ok;

    // Seconds history, alarm time storage and set-error pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sec_d      <= '0;
            r_alarm_hour <= '0;
            r_alarm_min  <= '0;
            r_set_err    <= 1'b0;
        end else begin
            r_sec_d   <= i_sec;
            r_set_err <= w_set_bad;
            if (w_set_ok) begin
                r_alarm_hour <= i_set_hour;
                r_alarm_min  <= i_set_min;
            end
        end
    end

    // State and countdown registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_ring_cnt <= '0;
            r_snz_cnt  <= '0;
        end else begin
            r_state    <= w_state_d;
            r_ring_cnt <= w_ring_cnt_d;
            r_snz_cnt  <= w_snz_cnt_d;
        end
    end

    // Next state: disarm beats a valid set, which beats stop, snooze and timers.
    always_comb begin
        w_state_d    = r_state;
        w_ring_cnt_d = r_ring_cnt;
        w_snz_cnt_d  = r_snz_cnt;
        if (!i_arm) begin
            w_state_d    = StIdle;
            w_ring_cnt_d = '0;
            w_snz_cnt_d  = '0;
        end else if (w_set_ok) begin
            w_state_d = StArmed;
        end else begin
            unique case (r_state)
                StIdle: begin
                    w_state_d = StArmed;
                end
                StArmed: begin
                    if (w_match) begin
                        w_state_d    = StRinging;
                        w_ring_cnt_d = '0;
                    end
                end
                StRinging: begin
                    if (i_stop) begin
                        w_state_d = StArmed;
                    end else if (i_snooze) begin
                        w_state_d   = StSnooze;
                        w_snz_cnt_d = 12'(P_SNOOZE_SEC);
                    end else if (w_sec_tick) begin
                        if (r_ring_cnt == 8'(P_RING_SEC - 1)) begin
                            w_state_d = StArmed;
                        end else begin
                            w_ring_cnt_d = r_ring_cnt + 8'd1;
                        end
                    end
                end
                StSnooze: begin
                    if (i_stop) begin
                        w_state_d = StArmed;
                    end else if (w_sec_tick) begin
                        if (r_snz_cnt == 12'd1) begin
                            w_state_d    = StRinging;
                            w_ring_cnt_d = '0;
                        end else begin
                            w_snz_cnt_d = r_snz_cnt - 12'd1;
                        end
                    end
                end
                default: begin
                    w_state_d = StIdle;
                end
            endcase
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        o_ringing  = (r_state == StRinging);
        o_snoozing = (r_state == StSnooze);
        o_armed    = (r_state != StIdle);
    end

    assign o_alarm_hour = r_alarm_hour;
    assign o_alarm_min  = r_alarm_min;
    assign o_set_err    = r_set_err;

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Downstream consumer of the seconds/minutes/hours time-of-day outputs of the one-second generator / sec_count chain.
- Holds a programmable alarm time (hour:minute) and compares it against live time at every minute boundary.
- Runs an arm/ring/snooze state machine and drives a ringing output with auto-timeout and snooze countdown.

Parameters:
P_SEC_BIT, 6, width of seconds input
P_MIN_BIT, 6, width of minute input/alarm minute
P_HOUR_BIT, 5, width of hour input/alarm hour
P_RING_SEC, 60, ring duration in seconds before auto-stop (1..255)
P_SNOOZE_SEC, 300, snooze length in seconds (1..4095)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
i_sec  input  P_SEC_BIT  current seconds (0..59) from sec_count
i_minute  input  P_MIN_BIT  current minutes (0..59)
i_hour  input  P_HOUR_BIT  current hours (0..23)
i_arm  input  1  level; 1 = alarm enabled
i_set_en  input  1  one-cycle strobe: load alarm time
i_set_hour  input  P_HOUR_BIT  alarm hour to load
i_set_min  input  P_MIN_BIT  alarm minute to load
i_snooze  input  1  one-cycle strobe: snooze request
i_stop  input  1  one-cycle strobe: stop request
o_ringing  output  1  alarm sounding
o_snoozing  output  1  snooze countdown active
o_armed  output  1  state is not IDLE
o_alarm_hour  output  P_HOUR_BIT  stored alarm hour
o_alarm_min  output  P_MIN_BIT  stored alarm minute
o_set_err  output  1  one-cycle pulse: rejected set request

Behaviour:
- Reset (reset=0, async): state IDLE; alarm regs 0:00; r_sec_d=0; ring/snooze counters 0; all outputs 0.
- Second tick: sec_tick = (i_sec != r_sec_d); r_sec_d <= i_sec every clk. Minute boundary = sec_tick && i_sec==0.
- Match = minute boundary && i_minute==o_alarm_min && i_hour==o_alarm_hour (uses alarm regs before any same-cycle set).
- Set: i_set_en with i_set_hour<=23 and i_set_min<=59 loads regs next edge; else regs unchanged, o_set_err=1 for exactly one cycle. Accepted set while RINGING/SNOOZE forces ARMED (if i_arm=1).
- States: IDLE, ARMED, RINGING, SNOOZE. Per-cycle priority: i_arm=0 > accepted set > i_stop > i_snooze > counter expiry/match.
- IDLE: i_arm=1 -> ARMED next edge.
- ARMED: i_arm=0 -> IDLE; match -> RINGING, ring_cnt<=0.
- RINGING: i_stop -> ARMED; i_snooze -> SNOOZE, snz_cnt<=P_SNOOZE_SEC; else ring_cnt++ on sec_tick; sec_tick with ring_cnt==P_RING_SEC-1 -> ARMED (auto-stop). Match ignored.
- SNOOZE: i_stop -> ARMED; i_snooze ignored; snz_cnt-- on sec_tick; sec_tick with snz_cnt==1 -> RINGING, ring_cnt<=0.
- Any -> IDLE when i_arm=0, counters cleared.
- Outputs registered, decoded from state: o_ringing=(RINGING), o_snoozing=(SNOOZE), o_armed=(state!=IDLE). Latency: o_ringing rises one clk edge after the cycle in which i_sec becomes 0 at matching time.
- Counters: ring_cnt 8b, snz_cnt 12b; never wrap (state exits before overflow).
- Time jump (upstream reset to 0:00:00 while ARMED with alarm 0:00): counts as sec_tick+match; ringing starts.

Test Plan:
- Reset low mid-RINGING -> all outputs 0 immediately (async), alarm regs 0:00, state IDLE after release.
- Set 07:30, i_arm=1, drive time 07:29:59 -> 07:30:00 -> o_ringing=1 one clk later; hold 60 ticks -> o_ringing=0 after 60th tick, o_armed=1.
- Ringing, pulse i_snooze -> o_snoozing=1; 300 ticks later o_ringing=1, o_snoozing=0; pulse i_stop -> o_ringing=0, ARMED.
- Set 24:10 and 12:60 -> o_set_err single-cycle pulse each, o_alarm_hour/min unchanged; set 23:59 -> accepted, no err.
- Same cycle i_stop and i_snooze while RINGING -> stop wins (ARMED); i_arm=0 with i_stop -> IDLE, o_armed=0.
- i_arm=0 at 07:30:00 match -> no ringing; time held at 07:30:00 (no sec change) after arming -> no ringing.
